// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised serial pattern detector:
// overlap-mode selectors, the legal pattern-length range and the
// default pattern loaded at reset.
package seq_det_pkg;

  localparam bit OVL_ON  = 1'b1;
  localparam bit OVL_OFF = 1'b0;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;

  localparam logic [2:0] DEFAULT_PAT = 3'b101;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for match statistics. Clear has priority
// over increment; the count sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise step up unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/sequence_detector_param.sv
// Bit-serial pattern detector with a run-time loadable pattern and
// don't-care mask. A history window collects valid bits; once the window
// is full, each new bit is compared under the mask and a match produces a
// registered one-cycle pulse and bumps a saturating match counter.
module sequence_detector_param
  import seq_det_pkg::*;
#(
  parameter int             PAT_W     = 3,
  parameter logic [PAT_W-1:0] PAT_INIT  = PAT_W'(DEFAULT_PAT),
  parameter logic [PAT_W-1:0] MASK_INIT = '1,
  parameter bit             OVERLAP   = OVL_ON,
  parameter int             CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [PAT_W-1:0] mask_in,
  output logic             detected,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam int               FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

  if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
    $error("sequence_detector_param: PAT_W out of legal range");
  end

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  mask_q, mask_d;
  logic              det_q, det_d;

  logic [PAT_W-1:0]  shifted;
  logic [FILL_W-1:0] fill_next;
  logic              match;
  logic              cnt_inc;
  logic              cnt_clr;

  // Next-state: clear beats pattern load beats an accepted bit; a match is
  // judged on the window as it will look after this bit shifts in.
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    mask_d    = mask_q;
    det_d     = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    shifted   = {hist_q[PAT_W-2:0], in_bit};
    fill_next = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    match     = (((shifted ^ pat_q) & mask_q) == '0) && (fill_next == FULL);

    if (clear) begin
      hist_d  = '0;
      fill_d  = '0;
      cnt_clr = 1'b1;
    end else if (pat_load) begin
      pat_d  = pat_in;
      mask_d = mask_in;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = shifted;
      fill_d = fill_next;
      if (match) begin
        det_d   = 1'b1;
        cnt_inc = 1'b1;
        if (OVERLAP == OVL_OFF) begin
          hist_d = '0;
          fill_d = '0;
        end
      end
    end
  end

  // State registers; reset restores the power-on pattern and mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PAT_INIT;
      mask_q <= MASK_INIT;
      det_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      mask_q <= mask_d;
      det_q  <= det_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .count (match_count)
  );

  assign detected = det_q;
  assign armed    = (fill_q == FULL);

endmodule

// File: tb/tb_sequence_detector_param.sv
// Bench for sequence_detector_param. Three instances share one input
// stream: the default overlapping 101 detector, a non-overlapping 101
// detector, and a 4-bit all-ones detector with a 2-bit counter. A queue
// based reference model tracks each one from the detection rules.
module tb_sequence_detector_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       inValid = 1'b0;
   logic       inBit = 1'b0;
   logic       clear = 1'b0;
   logic       patLoad = 1'b0;
   logic [2:0] patIn3 = '0;
   logic [2:0] maskIn3 = '0;
   logic [3:0] patIn4 = '0;
   logic [3:0] maskIn4 = '0;

   logic       det0, det1, det2;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;
   logic       armed0, armed1, armed2;

   int nChecks = 0;
   int nFails  = 0;

   // Reference model state, one slot per instance
   int W[3]     = '{3, 3, 4};
   bit OVL[3]   = '{1'b1, 1'b0, 1'b1};
   int CMAX[3]  = '{255, 255, 3};
   int INITP[3] = '{5, 5, 15};
   int pat[3];
   int mask[3];
   int cnt[3];
   bit det[3];
   bit hq[3][$];

   always #5 clk = ~clk;

   sequence_detector_param dut0 (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_bit(inBit),
      .clear(clear), .pat_load(patLoad), .pat_in(patIn3), .mask_in(maskIn3),
      .detected(det0), .match_count(cnt0), .armed(armed0)
   );

   sequence_detector_param #(.OVERLAP(1'b0)) dut1 (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_bit(inBit),
      .clear(clear), .pat_load(patLoad), .pat_in(patIn3), .mask_in(maskIn3),
      .detected(det1), .match_count(cnt1), .armed(armed1)
   );

   sequence_detector_param #(.PAT_W(4), .PAT_INIT(4'b1111), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_bit(inBit),
      .clear(clear), .pat_load(patLoad), .pat_in(patIn4), .mask_in(maskIn4),
      .detected(det2), .match_count(cnt2), .armed(armed2)
   );

   // Advance one instance's model by one clock edge using the stream rules
   task automatic modelStep(input int k, input bit r, input bit v, input bit b,
                            input bit c, input bit ld, input int p, input int m);
      int val;
      int allOnes;
      allOnes = (1 << W[k]) - 1;
      det[k] = 1'b0;
      if (r) begin
         hq[k].delete();
         pat[k]  = INITP[k];
         mask[k] = allOnes;
         cnt[k]  = 0;
      end else if (c) begin
         hq[k].delete();
         cnt[k] = 0;
      end else if (ld) begin
         hq[k].delete();
         pat[k]  = p & allOnes;
         mask[k] = m & allOnes;
      end else if (v) begin
         hq[k].push_back(b);
         if (hq[k].size() > W[k]) void'(hq[k].pop_front());
         if (hq[k].size() == W[k]) begin
            val = 0;
            for (int i = 0; i < W[k]; i++) val = val * 2 + int'(hq[k][i]);
            if (((val ^ pat[k]) & mask[k]) == 0) begin
               det[k] = 1'b1;
               if (cnt[k] < CMAX[k]) cnt[k]++;
               if (!OVL[k]) hq[k].delete();
            end
         end
      end
   endtask

   // One comparison: count it, and on mismatch count and report it
   task automatic checkOutput(input string tag, input int obs, input int exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Compare every output of every instance against the model
   task automatic checkAll(input string step);
      checkOutput({step, "_d0_det"}, int'(det0), int'(det[0]));
      checkOutput({step, "_d0_cnt"}, int'(cnt0), cnt[0]);
      checkOutput({step, "_d0_armed"}, int'(armed0), int'(hq[0].size() == W[0]));
      checkOutput({step, "_d1_det"}, int'(det1), int'(det[1]));
      checkOutput({step, "_d1_cnt"}, int'(cnt1), cnt[1]);
      checkOutput({step, "_d1_armed"}, int'(armed1), int'(hq[1].size() == W[1]));
      checkOutput({step, "_d2_det"}, int'(det2), int'(det[2]));
      checkOutput({step, "_d2_cnt"}, int'(cnt2), cnt[2]);
      checkOutput({step, "_d2_armed"}, int'(armed2), int'(hq[2].size() == W[2]));
   endtask

   // Drive one cycle of inputs, let the edge happen, update models, check
   task automatic applyStimulus(input string step, input bit r, input bit v, input bit b,
                                input bit c, input bit ld, input int p3, input int m3,
                                input int p4, input int m4);
      rst = r; inValid = v; inBit = b; clear = c; patLoad = ld;
      patIn3 = 3'(p3); maskIn3 = 3'(m3); patIn4 = 4'(p4); maskIn4 = 4'(m4);
      @(posedge clk);
      modelStep(0, r, v, b, c, ld, p3, m3);
      modelStep(1, r, v, b, c, ld, p3, m3);
      modelStep(2, r, v, b, c, ld, p4, m4);
      #1;
      checkAll(step);
   endtask

   task automatic sendBit(input string step, input bit b);
      applyStimulus(step, 1'b0, 1'b1, b, 1'b0, 1'b0, 0, 0, 0, 0);
   endtask

   task automatic idle(input string step);
      applyStimulus(step, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
   endtask

   // Directed scenarios first, then a randomized soak
   initial begin
      int p3, m3, p4, m4, sel;
      $display("[TB] start");

      applyStimulus("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
      applyStimulus("reset2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
      checkOutput("reset_d0_det_const", int'(det0), 0);
      checkOutput("reset_d0_cnt_const", int'(cnt0), 0);

      // 1,0,1,0,1: overlapping sees two matches, non-overlapping one
      sendBit("s1", 1'b1);
      sendBit("s2", 1'b0);
      sendBit("s3", 1'b1);
      checkOutput("s3_d0_pulse_const", int'(det0), 1);
      checkOutput("s3_d1_pulse_const", int'(det1), 1);
      checkOutput("s3_d1_armed_const", int'(armed1), 0);
      sendBit("s4", 1'b0);
      sendBit("s5", 1'b1);
      checkOutput("s5_d0_pulse_const", int'(det0), 1);
      checkOutput("s5_d1_nopulse_const", int'(det1), 0);
      checkOutput("s5_d0_cnt_const", int'(cnt0), 2);
      checkOutput("s5_d1_cnt_const", int'(cnt1), 1);

      // Gap of invalid cycles in the middle of a pattern
      applyStimulus("clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
      sendBit("g1", 1'b1);
      sendBit("g2", 1'b0);
      idle("gap1");
      idle("gap2");
      idle("gap3");
      sendBit("g3", 1'b1);
      checkOutput("g3_d0_pulse_const", int'(det0), 1);
      idle("g4");
      checkOutput("g4_d0_oneshot_const", int'(det0), 0);

      // Eight ones into the 4-bit all-ones detector saturate its counter
      for (int i = 0; i < 8; i++) sendBit($sformatf("ones%0d", i), 1'b1);
      checkOutput("ones_d2_pulse_const", int'(det2), 1);
      checkOutput("ones_d2_sat_const", int'(cnt2), 3);

      // Masked 4-bit pattern 1100 with bit 1 don't-care
      applyStimulus("load", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5, 7, 12, 13);
      sendBit("m1", 1'b1);
      sendBit("m2", 1'b1);
      sendBit("m3", 1'b1);
      sendBit("m4", 1'b0);
      checkOutput("m4_d2_masked_const", int'(det2), 1);
      sendBit("n1", 1'b1);
      sendBit("n2", 1'b0);
      sendBit("n3", 1'b1);
      sendBit("n4", 1'b0);

      // Clear arriving with the completing bit suppresses the match
      applyStimulus("clrload", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
      sendBit("c1", 1'b1);
      sendBit("c2", 1'b0);
      applyStimulus("c3clr", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
      checkOutput("c3_d0_nopulse_const", int'(det0), 0);
      checkOutput("c3_d0_cnt_const", int'(cnt0), 0);

      // Reset with a match pending
      sendBit("r1", 1'b1);
      sendBit("r2", 1'b0);
      applyStimulus("r3rst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
      checkOutput("r3_d0_nopulse_const", int'(det0), 0);

      // All-zero mask: every bit with a full window matches
      applyStimulus("zmask", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 9, 0);
      for (int i = 0; i < 5; i++) sendBit($sformatf("z%0d", i), 1'($urandom_range(0, 1)));

      // Randomized soak against the model
      for (int i = 0; i < 500; i++) begin
         sel = $urandom_range(0, 199);
         p3 = $urandom_range(0, 7);
         m3 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 7);
         p4 = $urandom_range(0, 15);
         m4 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
         applyStimulus($sformatf("rnd%0d", i), 1'(sel == 0), 1'($urandom_range(0, 9) < 8),
                       1'($urandom_range(0, 1)), 1'(sel >= 1 && sel <= 4),
                       1'(sel >= 3 && sel <= 7), p3, m3, p4, m4);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/sequence_detector_param.md
# sequence_detector_param

Parametrised serial pattern detector for bit-serial input streams, and the general successor to the fixed three-bit detector FSMs in the fsm family. It matches a run-time-loadable pattern of up to PAT_W bits, with a don't-care mask, and supports overlapping or non-overlapping detection. It gates input on a valid strobe and keeps a saturating match counter. It sits between a bit-serial source and control logic that needs a registered one-cycle match pulse plus match statistics.

## Interface
- PAT_W, 3: pattern length in bits, legal range 2..16.
- PAT_INIT, 3'b101: pattern value after reset; bit PAT_W-1 is the oldest bit, bit 0 the newest.
- MASK_INIT, all ones: compare mask after reset; a 0 bit means don't care.
- OVERLAP, 1: 1 allows overlapping matches; 0 restarts the search after each match.
- CNT_W, 8: width of the match counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bit is sampled only when high.
- in_bit  in  1  serial data bit.
- clear  in  1  flushes the history and zeroes match_count.
- pat_load  in  1  loads pat_in and mask_in.
- pat_in  in  PAT_W  new pattern.
- mask_in  in  PAT_W  new mask.
- detected  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating count of matches.
- armed  out  1  high when PAT_W valid bits have been collected since the last flush.

## Operation
- State: history shift register (PAT_W bits), fill counter (0..PAT_W), pattern/mask registers, match counter, detected register.
- Reset: history 0, fill 0, pattern=PAT_INIT, mask=MASK_INIT, detected 0, match_count 0, armed 0.
- Accepted bit (in_valid=1, no clear/pat_load): next history = {history[PAT_W-2:0], in_bit}. Fill increments and saturates at PAT_W.
- Match: next history AND mask equals pattern AND mask, and the fill after the shift equals PAT_W. On a match:
  - detected is 1 next cycle.
  - match_count increments, saturating at 2^CNT_W-1 with no wrap.
- OVERLAP=0: on a match, fill and history clear, so the next match needs PAT_W fresh bits.
- OVERLAP=1: history is kept after a match.
- in_valid=0: all state holds; detected is 0 next cycle.
- Priority when asserted together: rst > clear > pat_load > accepted bit.
  - clear: history and fill to 0, match_count to 0, detected 0 next cycle. The pattern is retained. pat_load in the same cycle is ignored.
  - pat_load: pattern and mask update, history and fill flush, match_count is kept. The bit presented that cycle is discarded.
- All-zero mask: every accepted bit with fill at PAT_W matches.
- armed = (fill == PAT_W).

## Timing
- Latency: detected rises exactly 1 cycle after the rising edge that sampled the completing bit, and lasts 1 cycle.
- match_count updates on the same edge that sets detected.
- No combinational path from any input to any output.
- Back-to-back matches (OVERLAP=1, pattern all ones) pulse detected on consecutive cycles.
- Reset mid-stream takes effect at the next edge. detected is 0 the cycle after rst, even if a match was pending.

## Structure
- Package seq_det_pkg holds:
  - overlap-mode constants OVL_ON and OVL_OFF;
  - the legal PAT_W bounds, for an elaboration-time check;
  - the default pattern constant.
- Sub-module sat_counter (parameter W; inputs inc and clr) implements match_count.
- Shift, compare and fill logic live in the top module.

## Test plan
- Default config (101, OVERLAP=1), stream 1,0,1,0,1 -> detected pulses after bits 3 and 5; match_count=2.
- OVERLAP=0, same stream -> single pulse after bit 3; match_count=1; armed drops after the match.
- Pattern 101, stream 1,0,[in_valid=0 for 3 cycles],1 -> one pulse, 1 cycle after the final valid bit; no pulse during the gap.
- pat_load pat_in=4'b1100 with mask_in=4'b1101 (PAT_W=4), stream 1,1,1,0 -> pulse (bit 1 don't-care); stream 1,0,1,0 -> no pulse.
- CNT_W=2, all-ones pattern with OVERLAP=1, 8 ones -> match_count reaches 3 and holds; detected keeps pulsing.
- clear asserted in the cycle a completing bit arrives -> no pulse, match_count=0, armed=0; rst mid-stream -> all outputs 0 next cycle.
